disp_source_arbiter: RTL and testbench

DISP_SOURCE_ARBITER -- requirements
Module: disp_source_arbiter

---
 rtl/disp_source_arbiter.sv | 122 ++++++++++++
 tb/tb_disp_source_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/disp_source_arbiter.sv
// Round-robin arbiter that hands the 4-digit display to one of three BCD
// sources for a fixed dwell, snapshotting the winner's value on each grant.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no owner, src_grant = 0, data_bcd keeps the last shown value
// HOLD  | one source owns the display, dwell counter running
module disp_source_arbiter #(
    parameter int unsigned HOLD_MAX = 26'd50_000_000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [2:0]  src_req,
    input  logic [15:0] src0_data,
    input  logic [15:0] src1_data,
    input  logic [15:0] src2_data,
    output logic [15:0] data_bcd,
    output logic [2:0]  src_grant,
    output logic        data_upd
);

    localparam int unsigned CW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(HOLD_MAX - 1);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    last, last_n;
    logic [2:0]    grant_n;
    logic [15:0]   data_n;
    logic          upd_n;

    logic          win_found;
    logic [1:0]    win_idx;
    logic [15:0]   win_data;
    logic          owner_req;
    logic          dwell_end;
    logic          load;

    // Round-robin search starting one past the last owner, wrapping 0,1,2.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 2'd0;
        for (int k = 1; k <= 3; k++) begin
            int unsigned cand;
            cand = (32'(last) + 32'(k)) % 3;
            if (!win_found && src_req[cand]) begin
                win_found = 1'b1;
                win_idx   = 2'(cand);
            end
        end
        case (win_idx)
            2'd0:    win_data = src0_data;
            2'd1:    win_data = src1_data;
            default: win_data = src2_data;
        endcase
    end

    // Next-state and next-output logic; an owner dropping its request ends the dwell early.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        last_n    = last;
        grant_n   = src_grant;
        data_n    = data_bcd;
        upd_n     = 1'b0;
        load      = 1'b0;
        owner_req = |(src_req & src_grant);
        dwell_end = !owner_req || (cnt == LAST_CNT);
        case (state)
            IDLE: begin
                if (win_found) load = 1'b1;
            end
            HOLD: begin
                if (dwell_end) begin
                    if (win_found) begin
                        load = 1'b1;
                    end else begin
                        state_n = IDLE;
                        grant_n = 3'b000;
                        cnt_n   = '0;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
        if (load) begin
            state_n = HOLD;
            grant_n = 3'(3'b001 << win_idx);
            data_n  = win_data;
            upd_n   = 1'b1;
            last_n  = win_idx;
            cnt_n   = '0;
        end
    end

    // State and registered outputs; pointer resets to 2 so source 0 is favoured first.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            last      <= 2'd2;
            src_grant <= 3'b000;
            data_bcd  <= 16'h0000;
            data_upd  <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            last      <= last_n;
            src_grant <= grant_n;
            data_bcd  <= data_n;
            data_upd  <= upd_n;
        end
    end

endmodule

// File: tb/tb_disp_source_arbiter.sv
// Bench for disp_source_arbiter with a short dwell: directed scenarios then
// randomized traffic, all checked against a behavioural owner/age model.
module tb_disp_source_arbiter;

    localparam int HOLD = 8;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [2:0]  src_req = 3'b000;
    logic [15:0] src0_data = 16'h0000;
    logic [15:0] src1_data = 16'h0000;
    logic [15:0] src2_data = 16'h0000;
    logic [15:0] data_bcd;
    logic [2:0]  src_grant;
    logic        data_upd;

    int vectors = 0;
    int miscompares = 0;

    // Model: owner index (-1 = nobody), last owner, cycles since load.
    int          m_owner = -1;
    int          m_last  = 2;
    int          m_age   = 0;
    logic [15:0] m_data  = 16'h0000;
    logic        m_upd   = 1'b0;
    int          pulses;

    disp_source_arbiter #(.HOLD_MAX(HOLD)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .src_req   (src_req),
        .src0_data (src0_data),
        .src1_data (src1_data),
        .src2_data (src2_data),
        .data_bcd  (data_bcd),
        .src_grant (src_grant),
        .data_upd  (data_upd)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [2:0] r, input int last);
        for (int k = 1; k <= 3; k++) begin
            int i;
            i = (last + k) % 3;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = 2;
        m_age   = 0;
        m_data  = 16'h0000;
        m_upd   = 1'b0;
    endtask

    task automatic model_step();
        int w;
        m_upd = 1'b0;
        if (m_owner < 0 || !src_req[m_owner] || m_age == HOLD - 1) begin
            w = pick(src_req, m_last);
            if (w >= 0) begin
                m_owner = w;
                m_last  = w;
                m_age   = 0;
                m_upd   = 1'b1;
                m_data  = (w == 0) ? src0_data : (w == 1) ? src1_data : src2_data;
            end else begin
                m_owner = -1;
            end
        end else begin
            m_age++;
        end
    endtask

    task automatic check_all(input string tag);
        logic [2:0] eg;
        eg = (m_owner < 0) ? 3'b000 : 3'(3'b001 << m_owner);
        chk({tag, "_grant"}, 16'(src_grant), 16'(eg));
        chk({tag, "_data"}, data_bcd, m_data);
        chk({tag, "_upd"}, 16'(data_upd), 16'(m_upd));
        chk({tag, "_onehot"}, 16'($onehot0(src_grant)), 16'd1);
    endtask

    task automatic step(input string tag);
        model_step();
        @(posedge sys_clk);
        #1;
        check_all(tag);
        pulses += int'(data_upd);
    endtask

    task automatic do_reset(input string tag);
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    initial begin
        // Reset values while held in reset.
        #12;
        check_all("reset");
        @(negedge sys_clk);
        sys_rst_n = 1'b1;

        // Single request from source 1.
        src1_data = 16'h1234;
        src_req   = 3'b010;
        step("r028");
        chk("r028_lit_grant", 16'(src_grant), 16'h0002);
        chk("r028_lit_data", data_bcd, 16'h1234);
        src_req = 3'b000;
        step("r028_off");
        chk("r028_lit_single_pulse", 16'(data_upd), 16'h0000);
        step("r028_idle");

        // All three requesting: strict rotation at HOLD spacing.
        do_reset("r029_rst");
        src0_data = 16'h0001; src1_data = 16'h0002; src2_data = 16'h0003;
        src_req = 3'b111;
        pulses = 0;
        for (int i = 1; i <= 3 * HOLD + 1; i++) begin
            step("r029");
            if (i == 1)            chk("r029_g0", 16'(src_grant), 16'h0001);
            if (i == HOLD + 1)     chk("r029_g1", 16'(src_grant), 16'h0002);
            if (i == 2 * HOLD + 1) chk("r029_g2", 16'(src_grant), 16'h0004);
            if (i == 3 * HOLD + 1) chk("r029_g3", data_bcd, 16'h0001);
        end
        chk("r029_pulses", 16'(pulses), 16'd4);

        // Data frozen during dwell, reloaded from the same owner at dwell end.
        do_reset("r030_rst");
        src0_data = 16'h0011;
        src_req   = 3'b001;
        step("r030_load");
        step("r030");
        step("r030");
        src0_data = 16'h0022;
        for (int i = 0; i < HOLD - 3; i++) begin
            step("r030_hold");
            chk("r030_frozen", data_bcd, 16'h0011);
        end
        step("r030_reload");
        chk("r030_lit_data", data_bcd, 16'h0022);
        chk("r030_lit_upd", 16'(data_upd), 16'h0001);

        // Owner drops mid-dwell, another source takes over at once.
        do_reset("r031_rst");
        src0_data = 16'h9A5C;
        src2_data = 16'h0777;
        src_req   = 3'b100;
        for (int i = 0; i < 4; i++) step("r031_hold");
        src_req = 3'b001;
        step("r031_switch");
        chk("r031_lit_grant", 16'(src_grant), 16'h0001);
        chk("r031_lit_data", data_bcd, 16'h9A5C);

        // All requests drop mid-dwell: IDLE, data retained, no pulse.
        do_reset("r032_rst");
        src0_data = 16'h4321;
        src_req   = 3'b011;
        for (int i = 0; i < 3; i++) step("r032_hold");
        src_req = 3'b000;
        step("r032_idle");
        chk("r032_lit_grant", 16'(src_grant), 16'h0000);
        chk("r032_lit_data", data_bcd, 16'h4321);

        // Reset mid-dwell, source 0 favoured afterwards.
        src_req = 3'b111;
        for (int i = 0; i < 5; i++) step("r033_pre");
        do_reset("r033_rst");
        chk("r033_lit_zero", data_bcd, 16'h0000);
        step("r033_post");
        chk("r033_lit_grant", 16'(src_grant), 16'h0001);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(3) == 0) src_req = 3'($urandom_range(7));
            if ($urandom_range(7) == 0) src0_data = 16'($urandom);
            if ($urandom_range(7) == 0) src1_data = 16'($urandom);
            if ($urandom_range(7) == 0) src2_data = 16'($urandom);
            if ($urandom_range(199) == 0) do_reset("rand_rst");
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
